// File: rtl/cpu_controller_if.sv
// Control bus between the sequencing controller and the accumulator datapath.
// The master side is the controller. It drives the strobes and receives the opcode, flag and memory handshake.
interface cpu_controller_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [3:0]             opcode;
  logic                   zero_flag;
  logic                   mem_ready;
  logic                   MemRead;
  logic                   LoadIR;
  logic                   IncPC;
  logic                   LoadPC;
  logic                   LoadAcc;
  logic [1:0]             SelAcc;
  logic                   LoadReg;
  logic [2:0]             alu_op;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    input  opcode, zero_flag, mem_ready,
    output MemRead, LoadIR, IncPC, LoadPC, LoadAcc, SelAcc, LoadReg,
           alu_op, halted, instr_count
  );

  modport slave (
    output opcode, zero_flag, mem_ready,
    input  MemRead, LoadIR, IncPC, LoadPC, LoadAcc, SelAcc, LoadReg,
           alu_op, halted, instr_count
  );
endinterface

// File: rtl/cpu_controller.sv
// Fetch / load / execute sequencer for the 8-bit accumulator datapath.
// The strobes are decoded combinationally from the state and the opcode.
// The state and the retired-instruction counter are registered.
module cpu_controller #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  cpu_controller_if.master  bus
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [3:0] OP_HLT = 4'hF;

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [COUNT_WIDTH-1:0] count_q;

  logic       mem_read;
  logic       load_ir;
  logic       inc_pc;
  logic       load_pc;
  logic       load_acc;
  logic [1:0] sel_acc;
  logic       load_reg;
  logic [2:0] alu_function;
  logic       halted;

  // State register. Reset returns the controller to FETCH immediately.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: use non-blocking assignments for every flop so that all state updates see the pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // The retired-instruction counter advances on each edge that ends an EXECUTE cycle and wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     count_q <= '0;
    else if (state_q == S_EXECUTE) count_q <= count_q + COUNT_WIDTH'(1);
  end

  // Next-state sequencing. mem_ready only matters in FETCH. HALT is left only through reset.
  always_comb begin
    // NOTE: assign a default before the case so that no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_LOAD;
      S_LOAD:    state_d = S_EXECUTE;
      S_EXECUTE: state_d = (bus.opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Strobe decode. Every output is held low while reset is asserted, so no partial strobe escapes.
  always_comb begin
    mem_read     = 1'b0;
    load_ir      = 1'b0;
    inc_pc       = 1'b0;
    load_pc      = 1'b0;
    load_acc     = 1'b0;
    sel_acc      = 2'b00;
    load_reg     = 1'b0;
    alu_function = 3'b000;
    halted       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: mem_read = 1'b1;
        S_LOAD: begin
          load_ir = 1'b1;
          inc_pc  = 1'b1;
        end
        S_EXECUTE: begin
          case (bus.opcode)
            4'h0: ;                                              // NOP
            4'h1: begin sel_acc = 2'b01; load_acc = 1'b1; end    // LDI
            4'h2: begin sel_acc = 2'b10; load_acc = 1'b1; end    // LDR
            4'h3: load_reg = 1'b1;                               // STR
            4'h4: begin alu_function = 3'b000; load_acc = 1'b1; end
            4'h5: begin alu_function = 3'b001; load_acc = 1'b1; end
            4'h6: begin alu_function = 3'b010; load_acc = 1'b1; end
            4'h7: begin alu_function = 3'b011; load_acc = 1'b1; end
            4'h8: begin alu_function = 3'b100; load_acc = 1'b1; end
            4'h9: begin alu_function = 3'b101; load_acc = 1'b1; end
            4'hA: begin alu_function = 3'b110; load_acc = 1'b1; end
            4'hB: begin alu_function = 3'b111; load_acc = 1'b1; end
            4'hC: load_pc = 1'b1;                                // JMP
            4'hD: load_pc = bus.zero_flag;                       // JZ
            4'hE: load_pc = ~bus.zero_flag;                      // JNZ
            4'hF: ;                                              // HLT
            default: ;
          endcase
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.MemRead     = mem_read;
  assign bus.LoadIR      = load_ir;
  assign bus.IncPC       = inc_pc;
  assign bus.LoadPC      = load_pc;
  assign bus.LoadAcc     = load_acc;
  assign bus.SelAcc      = sel_acc;
  assign bus.LoadReg     = load_reg;
  assign bus.alu_op      = alu_function;
  assign bus.halted      = halted;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller. The outputs are packed as
// {MemRead, LoadIR, IncPC, LoadPC, LoadAcc, SelAcc[1:0], LoadReg, alu_op[2:0], halted}
// and compared against hand-computed constants.
module tb_cpu_controller;

  logic clock;
  logic reset;
  logic rst_b;

  int total = 0;
  int bad   = 0;

  cpu_controller_if #(.COUNT_WIDTH(8)) bus_a ();
  cpu_controller_if #(.COUNT_WIDTH(4)) bus_b ();

  cpu_controller #(.COUNT_WIDTH(8)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  cpu_controller #(.COUNT_WIDTH(4)) dut_b (.clock(clock), .reset(rst_b), .bus(bus_b));

  logic [11:0] obs_a;
  assign obs_a = {bus_a.MemRead, bus_a.LoadIR, bus_a.IncPC, bus_a.LoadPC, bus_a.LoadAcc,
                  bus_a.SelAcc, bus_a.LoadReg, bus_a.alu_op, bus_a.halted};

  localparam logic [11:0] E_NONE  = 12'h000;
  localparam logic [11:0] E_FETCH = 12'h800;
  localparam logic [11:0] E_LOAD  = 12'h600;
  localparam logic [11:0] E_LDI   = 12'h0A0;
  localparam logic [11:0] E_LDR   = 12'h0C0;
  localparam logic [11:0] E_STR   = 12'h010;
  localparam logic [11:0] E_ADD   = 12'h080;
  localparam logic [11:0] E_SUB   = 12'h082;
  localparam logic [11:0] E_SHR   = 12'h08E;
  localparam logic [11:0] E_JUMP  = 12'h100;
  localparam logic [11:0] E_HALT  = 12'h001;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Step into the next cycle, away from the active edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Starting in a FETCH cycle with mem_ready high, run LOAD and EXECUTE for one opcode.
  // The bench returns one cycle after EXECUTE.
  task automatic do_instr(input string tag, input logic [3:0] op, input logic zf,
                          input logic [11:0] exp_exec);
    tick();
    check({tag, "_load"}, 32'(obs_a), 32'(E_LOAD));
    tick();
    bus_a.opcode    = op;
    bus_a.zero_flag = zf;
    #1;
    check({tag, "_exec"}, 32'(obs_a), 32'(exp_exec));
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    rst_b           = 1'b1;
    bus_a.mem_ready = 1'b1;
    bus_a.opcode    = 4'h0;
    bus_a.zero_flag = 1'b0;
    bus_b.mem_ready = 1'b1;
    bus_b.opcode    = 4'h0;
    bus_b.zero_flag = 1'b0;

    // Reset holds every output low, including MemRead.
    #3;
    check("reset_outputs", 32'(obs_a), 32'(E_NONE));
    check("reset_count", 32'(bus_a.instr_count), 0);
    tick();
    check("reset_outputs_held", 32'(obs_a), 32'(E_NONE));

    // Cycle 1 after release: FETCH. A stray opcode outside EXECUTE has no effect.
    tick();
    reset        = 1'b0;
    bus_a.opcode = 4'hB;
    #1;
    check("c1_fetch", 32'(obs_a), 32'(E_FETCH));
    do_instr("c2c3_ldi", 4'h1, 1'b0, E_LDI);
    check("c4_fetch", 32'(obs_a), 32'(E_FETCH));
    check("count_after_ldi", 32'(bus_a.instr_count), 1);
    do_instr("c5c6_add", 4'h4, 1'b0, E_ADD);
    check("count_after_add", 32'(bus_a.instr_count), 2);

    // Stall in FETCH for 4 cycles. MemRead is held for 5 cycles and the instruction takes 7.
    bus_a.mem_ready = 1'b0;
    bus_a.opcode    = 4'h1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_fetch", 32'(obs_a), 32'(E_FETCH));
      tick();
    end
    bus_a.mem_ready = 1'b1;
    #1;
    check("stall_fetch_last", 32'(obs_a), 32'(E_FETCH));
    tick();
    bus_a.mem_ready = 1'b0;  // ignored outside FETCH
    #1;
    check("stall_load", 32'(obs_a), 32'(E_LOAD));
    tick();
    bus_a.opcode = 4'h5;
    #1;
    check("stall_exec_sub", 32'(obs_a), 32'(E_SUB));
    check("stall_count_hold", 32'(bus_a.instr_count), 2);
    tick();
    check("stall_count", 32'(bus_a.instr_count), 3);
    bus_a.mem_ready = 1'b1;
    #1;

    // Remaining decodes and jump conditions.
    do_instr("ldr", 4'h2, 1'b0, E_LDR);
    do_instr("str", 4'h3, 1'b1, E_STR);
    do_instr("shr", 4'hB, 1'b0, E_SHR);
    do_instr("jz_taken", 4'hD, 1'b1, E_JUMP);
    do_instr("jz_not", 4'hD, 1'b0, E_NONE);
    do_instr("jnz_taken", 4'hE, 1'b0, E_JUMP);
    do_instr("jnz_not", 4'hE, 1'b1, E_NONE);
    do_instr("jmp_z0", 4'hC, 1'b0, E_JUMP);
    do_instr("jmp_z1", 4'hC, 1'b1, E_JUMP);
    do_instr("nop", 4'h0, 1'b1, E_NONE);
    check("count_before_hlt", 32'(bus_a.instr_count), 13);

    // HLT counts as an instruction. After it, only halted stays high.
    do_instr("hlt", 4'hF, 1'b0, E_NONE);
    for (int i = 0; i < 22; i++) begin
      bus_a.opcode = 4'(i);
      #1;
      check("halt_outputs", 32'(obs_a), 32'(E_HALT));
      check("halt_count", 32'(bus_a.instr_count), 14);
      tick();
    end
    reset = 1'b1;
    #1;
    check("halt_reset_outputs", 32'(obs_a), 32'(E_NONE));
    check("halt_reset_count", 32'(bus_a.instr_count), 0);
    tick();
    reset        = 1'b0;
    bus_a.opcode = 4'h0;
    #1;
    check("halt_resume_fetch", 32'(obs_a), 32'(E_FETCH));

    // Reset mid-LOAD.
    do_instr("pre_load_rst", 4'h1, 1'b0, E_LDI);
    tick();
    check("mid_load", 32'(obs_a), 32'(E_LOAD));
    reset = 1'b1;
    #1;
    check("load_rst_outputs", 32'(obs_a), 32'(E_NONE));
    check("load_rst_count", 32'(bus_a.instr_count), 0);
    tick();
    reset = 1'b0;
    #1;
    check("load_rst_fetch", 32'(obs_a), 32'(E_FETCH));

    // Reset mid-EXECUTE.
    tick();
    check("pre_exec_load", 32'(obs_a), 32'(E_LOAD));
    tick();
    bus_a.opcode = 4'h1;
    #1;
    check("mid_exec", 32'(obs_a), 32'(E_LDI));
    reset = 1'b1;
    #1;
    check("exec_rst_outputs", 32'(obs_a), 32'(E_NONE));
    check("exec_rst_count", 32'(bus_a.instr_count), 0);
    tick();
    reset = 1'b0;
    #1;
    check("exec_rst_fetch", 32'(obs_a), 32'(E_FETCH));
    check("exec_rst_count_hold", 32'(bus_a.instr_count), 0);

    // 4-bit counter wrap with NOPs streaming at 3 cycles each.
    rst_b = 1'b0;
    #1;
    check("w4_start", 32'(bus_b.instr_count), 0);
    for (int k = 1; k <= 17; k++) begin
      tick(); tick(); tick();
      if (k >= 14) check("w4_count", 32'(bus_b.instr_count), 32'(k % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Sequencing controller for the 8-bit accumulator datapath. It consumes the 4-bit opcode produced by the instruction register and drives `LoadIR` back to it. It also drives the program counter, accumulator, register file and ALU control strobes, and implements a fetch → load → execute state machine with a memory-ready handshake and a halt state.

## Interface
- `COUNT_WIDTH`, default 8: width of the retired-instruction counter.

- `clock` in 1: clock, positive-edge triggered.
- `reset` in 1: reset, asynchronous, active-high.
- `opcode` in 4: opcode field from the instruction register. Valid in EXECUTE.
- `zero_flag` in 1: accumulator-zero flag from the ALU.
- `mem_ready` in 1: instruction memory has valid data on its output this cycle.
- `MemRead` out 1: instruction fetch request, addressed by PC.
- `LoadIR` out 1: load the instruction register.
- `IncPC` out 1: PC ← PC + 1.
- `LoadPC` out 1: PC ← immediate field (jump).
- `LoadAcc` out 1: accumulator load strobe.
- `SelAcc` out 2: accumulator source. 00 = ALU, 01 = immediate, 10 = register file.
- `LoadReg` out 1: register file write (reg[data] ← acc).
- `alu_op` out 3: ALU function.
- `halted` out 1: high in HALT state.
- `instr_count` out `COUNT_WIDTH`: number of instructions executed.

## Operation
- States: FETCH, LOAD, EXECUTE, HALT. Encoding is free.
- FETCH:
  - `MemRead` = 1.
  - Stay in FETCH while `mem_ready` = 0.
  - Go to LOAD when `mem_ready` = 1.
- LOAD:
  - `LoadIR` = 1 and `IncPC` = 1 for exactly one cycle.
  - Always go to EXECUTE.
  - The IR captures on the edge that ends LOAD, so `opcode` is valid throughout EXECUTE.
- EXECUTE: decode `opcode` for one cycle, then go to FETCH. HLT goes to HALT instead.
- HALT: all strobes 0, `halted` = 1. Leave only via `reset`.
- Opcode map (EXECUTE outputs; all unlisted strobes 0, `SelAcc` = 00, `alu_op` = 000):
  - 0 NOP: none.
  - 1 LDI: `SelAcc` = 01, `LoadAcc`.
  - 2 LDR: `SelAcc` = 10, `LoadAcc`.
  - 3 STR: `LoadReg`.
  - 4 ADD: `alu_op` = 000, `LoadAcc`.
  - 5 SUB: `alu_op` = 001, `LoadAcc`.
  - 6 AND: `alu_op` = 010, `LoadAcc`.
  - 7 OR: `alu_op` = 011, `LoadAcc`.
  - 8 XOR: `alu_op` = 100, `LoadAcc`.
  - 9 NOT: `alu_op` = 101, `LoadAcc`.
  - A SHL: `alu_op` = 110, `LoadAcc`.
  - B SHR: `alu_op` = 111, `LoadAcc`.
  - C JMP: `LoadPC`.
  - D JZ: `LoadPC` = `zero_flag`.
  - E JNZ: `LoadPC` = !`zero_flag`.
  - F HLT: no strobes, next state HALT.
- `instr_count`:
  - Increments by 1 on every clock edge that ends an EXECUTE cycle, HLT included.
  - Wraps from all-ones to 0.
  - Holds in FETCH, LOAD and HALT.
- `LoadPC` and `IncPC` are never high in the same cycle. `IncPC` occurs only in LOAD, `LoadPC` only in EXECUTE.

## Timing
- Reset:
  - State → FETCH and `instr_count` → 0, asynchronously.
  - While `reset` is high, every output is forced to 0, including `MemRead`.
  - The first `MemRead` appears in the first cycle after `reset` deasserts.
- Strobes are combinational from the current state, `opcode` and `zero_flag`. Next-state logic and `instr_count` are registered.
- Latency with `mem_ready` tied high: 3 cycles per instruction (FETCH, LOAD, EXECUTE), and EXECUTE strobes take effect on the edge that ends EXECUTE.
- Each cycle of `mem_ready` = 0 in FETCH adds one cycle.
- `mem_ready` is ignored outside FETCH.
- `zero_flag` is sampled combinationally during EXECUTE only. It reflects the accumulator value before this instruction's write.
- Reset mid-instruction (any state, including HALT): immediate return to FETCH with `instr_count` = 0. Partial strobes are abandoned and no `LoadIR` completes. The IR clears itself to NOP on the same reset.
- `opcode` changes outside EXECUTE have no effect on outputs.

## Test plan
- Reset, then `mem_ready` = 1, instruction stream 0x15 (LDI 5), 0x42 (ADD r2):
  - `MemRead` in cycle 1, `LoadIR` + `IncPC` in cycle 2.
  - Cycle 3: `SelAcc` = 01, `LoadAcc` = 1.
  - Cycle 6: `alu_op` = 000, `SelAcc` = 00, `LoadAcc` = 1.
  - `instr_count` = 2 after cycle 6.
- `mem_ready` low for 4 cycles in FETCH:
  - `MemRead` held 5 cycles.
  - `LoadIR` only in the cycle after `mem_ready` rises.
  - Instruction takes 7 cycles.
- Jumps:
  - JZ (0xD7) with `zero_flag` = 1 → `LoadPC` = 1 in EXECUTE.
  - JZ with `zero_flag` = 0 → `LoadPC` = 0.
  - JNZ with `zero_flag` = 0 → `LoadPC` = 1.
  - JMP → `LoadPC` = 1 regardless of flag.
- HLT (0xF0):
  - `halted` = 1 from the cycle after EXECUTE.
  - `MemRead`, `LoadIR` and `IncPC` stay 0 for 20+ cycles; `instr_count` frozen.
  - Then `reset` → `halted` = 0 and fetch resumes.
- Reset asserted mid-LOAD and mid-EXECUTE:
  - All outputs 0 immediately (same cycle, asynchronous).
  - `instr_count` = 0, next state after release is FETCH.
- `COUNT_WIDTH` = 4, 17 NOPs executed: `instr_count` reads 15 after 15, 0 after 16, 1 after 17.
